// File: rtl/ram_scan_if.sv
// ram_scan_if: command and stream handshakes between the checkpoint
// buffer/DMA (master) and the RAM scan-chain controller (slave).
interface ram_scan_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic                  busy;
  logic                  done;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;

  modport master (
    output cmd_valid, cmd_dir, dump_ready, load_valid, load_data,
    input  cmd_ready, busy, done, dump_valid, dump_data, load_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, dump_ready, load_valid, load_data,
    output cmd_ready, busy, done, dump_valid, dump_data, load_ready
  );
endinterface

// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: pauses the emulated DUT, then dumps (chain -> stream) or
// restores (stream -> chain) exactly WORDS scan words, gating the RAM clock
// so that a stalled stream freezes the chain.
// Optional feature: define RAM_SCAN_CHECKSUM_EN to add a rotate-XOR
// checksum output over every transferred word.
module ram_scan_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int WORDS      = 16,
  parameter int PRE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_scan_if.slave             bus,
  output logic                  dut_pause,
  output logic                  ram_clk_en,
  output logic                  emu_ram_se,
  output logic                  emu_ram_sd,
  output logic [DATA_WIDTH-1:0] emu_ram_di,
  input  logic [DATA_WIDTH-1:0] emu_ram_do
`ifdef RAM_SCAN_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam int CW = $clog2(WORDS + 1);
  localparam int PW = $clog2(PRE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PAUSE = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_UNSE  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic          dir_r;
  logic [CW-1:0] cnt_r;
  logic [PW-1:0] pre_r;

  logic cmd_hs_s;
  logic xfer_hs_s;

  logic                  cmd_ready_s;
  logic                  busy_s;
  logic                  done_s;
  logic                  dump_valid_s;
  logic                  load_ready_s;
  logic                  pause_s;
  logic                  clk_en_s;
  logic                  se_s;
  logic                  sd_s;
  logic [DATA_WIDTH-1:0] di_s;

  assign cmd_hs_s  = (state_r == S_IDLE) && bus.cmd_valid;
  // Handshake side depends only on the latched direction, never on the peer.
  assign xfer_hs_s = (state_r == S_XFER) &&
                     (dir_r ? bus.load_valid : bus.dump_ready);

  // Next-state selection for the scan sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.cmd_valid) state_nxt_s = S_PAUSE;
        else               state_nxt_s = S_IDLE;
      end
      S_PAUSE: begin
        if (dir_r) state_nxt_s = S_XFER;
        else       state_nxt_s = S_PRE;
      end
      S_PRE: begin
        if (pre_r == PRE_LAST) state_nxt_s = S_XFER;
        else                   state_nxt_s = S_PRE;
      end
      S_XFER: begin
        if (xfer_hs_s && (cnt_r == LAST_WORD)) begin
          if (dir_r) state_nxt_s = S_POST;
          else       state_nxt_s = S_UNSE;
        end else begin
          state_nxt_s = S_XFER;
        end
      end
      S_POST:  state_nxt_s = S_UNSE;
      S_UNSE:  state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register plus direction latch and word / fill counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      dir_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      pre_r   <= {PW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (cmd_hs_s) begin
        dir_r <= bus.cmd_dir;
        cnt_r <= {CW{1'b0}};
        pre_r <= {PW{1'b0}};
      end else begin
        if (state_r == S_PRE) pre_r <= pre_r + {{(PW-1){1'b0}}, 1'b1};
        // Counter stops at WORDS on the terminal handshake; it never wraps.
        if (xfer_hs_s) cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Output decode from the state register; the RAM clock follows the
  // stream handshake in XFER so a stall freezes the chain.
  always_comb begin
    cmd_ready_s  = 1'b0;
    done_s       = 1'b0;
    dump_valid_s = 1'b0;
    load_ready_s = 1'b0;
    pause_s      = 1'b0;
    clk_en_s     = 1'b0;
    se_s         = 1'b0;
    sd_s         = 1'b0;
    di_s         = {DATA_WIDTH{1'b0}};
    case (state_r)
      S_IDLE: begin
        cmd_ready_s = 1'b1;
        clk_en_s    = 1'b1;
      end
      S_PAUSE: begin
        pause_s = 1'b1;
      end
      S_PRE: begin
        pause_s  = 1'b1;
        se_s     = 1'b1;
        clk_en_s = 1'b1;
      end
      S_XFER: begin
        pause_s = 1'b1;
        se_s    = 1'b1;
        sd_s    = dir_r;
        if (dir_r) begin
          load_ready_s = 1'b1;
          di_s         = bus.load_data;
          clk_en_s     = bus.load_valid;
        end else begin
          dump_valid_s = 1'b1;
          clk_en_s     = bus.dump_ready;
        end
      end
      S_POST: begin
        pause_s  = 1'b1;
        se_s     = 1'b1;
        sd_s     = 1'b1;
        clk_en_s = 1'b1;
      end
      S_UNSE: begin
        pause_s = 1'b1;
      end
      S_DONE: begin
        done_s   = 1'b1;
        clk_en_s = 1'b1;
      end
      default: begin
        cmd_ready_s = 1'b0;
      end
    endcase
  end

  assign busy_s         = (state_r != S_IDLE);
  assign bus.cmd_ready  = cmd_ready_s;
  assign bus.busy       = busy_s;
  assign bus.done       = done_s;
  assign bus.dump_valid = dump_valid_s;
  assign bus.dump_data  = emu_ram_do;
  assign bus.load_ready = load_ready_s;
  assign dut_pause      = pause_s;
  assign ram_clk_en     = clk_en_s;
  assign emu_ram_se     = se_s;
  assign emu_ram_sd     = sd_s;
  assign emu_ram_di     = di_s;

`ifdef RAM_SCAN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_r;
  logic [DATA_WIDTH-1:0] xfer_word_s;

  assign xfer_word_s = dir_r ? bus.load_data : emu_ram_do;

  // Rotate-left-by-one then XOR each transferred word; cleared per command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= {DATA_WIDTH{1'b0}};
    end else if (cmd_hs_s) begin
      checksum_r <= {DATA_WIDTH{1'b0}};
    end else if (xfer_hs_s) begin
      checksum_r <= {checksum_r[DATA_WIDTH-2:0], checksum_r[DATA_WIDTH-1]} ^ xfer_word_s;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

endmodule
